// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter: small byte FIFO feeding a start/data/stop shift FSM.
// The serial line is registered and the divisor is captured once per frame.
module uart_tx_core #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tx_en_i,
  input  logic [7:0]       tx_data_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic             ovf_clr_i,
  output logic             tx_o,
  output logic             t_done_o,
  output logic             busy_o,
  output logic             fifo_full_o,
  output logic             fifo_empty_o,
  output logic             overflow_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_countNext;
  logic             r_full;
  logic             r_empty;
  logic             r_ovf;
  logic             r_tx;
  logic             r_done;
  logic [7:0]       r_shift;
  logic [2:0]       r_bitIdx;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_timer;
  logic [DIV_W-1:0] w_divEff;
  logic             w_bitEnd;
  logic             w_pop;
  logic             w_push;
  logic             w_ovfSet;
  logic             w_txNext;
  logic             w_doneNext;

  assign w_bitEnd = (r_timer == '0);
  assign w_divEff = (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (!r_empty) w_nextState = START;
      START:   if (w_bitEnd) w_nextState = DATA;
      DATA:    if (w_bitEnd && r_bitIdx == 3'd7) w_nextState = STOP;
      STOP:    if (w_bitEnd) w_nextState = r_empty ? IDLE : START;
      default: w_nextState = IDLE;
    endcase
  end

  // The line value is decided one cycle ahead so tx_o can come straight from a flop.
  always_comb begin
    w_pop      = 1'b0;
    w_txNext   = r_tx;
    w_doneNext = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop    = !r_empty;
        w_txNext = r_empty;
      end
      START:   if (w_bitEnd) w_txNext = r_shift[0];
      DATA:    if (w_bitEnd) w_txNext = (r_bitIdx == 3'd7) ? 1'b1 : r_shift[1];
      STOP: begin
        if (w_bitEnd) begin
          w_doneNext = 1'b1;
          w_pop      = !r_empty;
          w_txNext   = r_empty;
        end
      end
      default: w_txNext = 1'b1;
    endcase
  end

  // A pop frees the head slot, so a write may land even when the FIFO is full.
  assign w_push      = tx_en_i && (!r_full || w_pop);
  assign w_ovfSet    = tx_en_i && r_full && !w_pop;
  assign w_countNext = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= tx_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= w_countNext;
      r_full  <= (w_countNext == FULL_CNT);
      r_empty <= (w_countNext == '0);
      if (w_ovfSet)       r_ovf <= 1'b1;
      else if (ovf_clr_i) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx     <= 1'b1;
      r_done   <= 1'b0;
      r_shift  <= '0;
      r_bitIdx <= '0;
      r_div    <= DIV_W'(1);
      r_timer  <= '0;
    end else begin
      r_tx   <= w_txNext;
      r_done <= w_doneNext;
      if (w_pop) begin
        r_shift  <= r_mem[r_rptr];
        r_div    <= w_divEff;
        r_timer  <= w_divEff - DIV_W'(1);
        r_bitIdx <= '0;
      end else if (r_state != IDLE) begin
        if (w_bitEnd) begin
          r_timer <= r_div - DIV_W'(1);
          if (r_state == DATA) begin
            r_shift  <= r_shift >> 1;
            r_bitIdx <= r_bitIdx + 3'd1;
          end
        end else begin
          r_timer <= r_timer - DIV_W'(1);
        end
      end
    end
  end

  assign tx_o         = r_tx;
  assign t_done_o     = r_done;
  assign busy_o       = (r_state != IDLE) | ~r_empty;
  assign fifo_full_o  = r_full;
  assign fifo_empty_o = r_empty;
  assign overflow_o   = r_ovf;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: a line monitor decodes every frame and checks it
// cycle by cycle against a queue of expected bytes and divisors.
module tb_uart_tx_core;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        tx_en_i = 1'b0;
  logic [7:0]  tx_data_i = '0;
  logic [15:0] baud_div_i = 16'd4;
  logic        ovf_clr_i = 1'b0;
  logic        tx_o;
  logic        t_done_o;
  logic        busy_o;
  logic        fifo_full_o;
  logic        fifo_empty_o;
  logic        overflow_o;

  uart_tx_core #(.FIFO_DEPTH(4), .DIV_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tx_en_i(tx_en_i), .tx_data_i(tx_data_i),
    .baud_div_i(baud_div_i), .ovf_clr_i(ovf_clr_i), .tx_o(tx_o),
    .t_done_o(t_done_o), .busy_o(busy_o), .fifo_full_o(fifo_full_o),
    .fifo_empty_o(fifo_empty_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] data;
    int         div;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    int          effDiv;
  } vec_t;

  exp_t expQ[$];
  int   doneTimes[$];
  int   testsRun = 0;
  int   testsFailed = 0;
  int   cycle = 0;
  int   doneCount = 0;
  int   strayDone = 0;
  logic prevTx = 1'b1;

  always @(posedge clk_i) cycle++;
  always @(negedge clk_i) if (t_done_o) doneCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one write strobe, sampled on the next rising edge; called at a falling edge.
  task automatic applyStimulus(input logic [7:0] data, input logic [15:0] div);
    baud_div_i = div;
    tx_data_i  = data;
    tx_en_i    = 1'b1;
    @(negedge clk_i);
    tx_en_i    = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (busy_o && n < budget);
    checkOutput("idleWithinBudget", {31'd0, busy_o}, 32'd0);
    repeat (2) @(negedge clk_i);
  endtask

  // Called on the first start-bit sample; consumes the frame plus the done cycle.
  task automatic monitorFrame(output bit aborted);
    exp_t       it;
    logic [9:0] bits;
    logic [7:0] got;
    int         bad;
    aborted = 1'b0;
    checkOutput("frameWasQueued", {31'd0, expQ.size() != 0}, 32'd1);
    if (expQ.size() != 0) it = expQ.pop_front();
    else begin
      it.data = 8'h00;
      it.div  = 1;
    end
    bits = {1'b1, it.data, 1'b0};
    got  = '0;
    bad  = 0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < it.div; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk_i);
        if (rst_i) begin
          aborted = 1'b1;
          return;
        end
        if (tx_o !== bits[b]) bad++;
        if (b >= 1 && b <= 8 && c == it.div / 2) got[b-1] = tx_o;
      end
    end
    checkOutput("frameData", {24'd0, got}, {24'd0, it.data});
    checkOutput("frameTimingErrors", bad, 0);
    @(negedge clk_i);
    if (rst_i) begin
      aborted = 1'b1;
      return;
    end
    checkOutput("doneAfterStop", {31'd0, t_done_o}, 32'd1);
    doneTimes.push_back(cycle);
  endtask

  always begin
    bit ab;
    @(negedge clk_i);
    if (rst_i) prevTx = 1'b1;
    else begin
      if (t_done_o) strayDone++;
      ab = 1'b0;
      while (!rst_i && prevTx && tx_o == 1'b0) begin
        monitorFrame(ab);
        if (ab) break;
      end
      prevTx = ab ? 1'b1 : tx_o;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   snap;
    vecs[0] = '{8'hA5, 16'd4, 4};
    vecs[1] = '{8'h00, 16'd1, 1};
    vecs[2] = '{8'hFF, 16'd3, 3};
    vecs[3] = '{8'h5A, 16'd0, 1};
    vecs[4] = '{8'h81, 16'd7, 7};
    vecs[5] = '{8'h3C, 16'd2, 2};

    @(negedge clk_i);
    checkOutput("resetTx", {31'd0, tx_o}, 32'd1);
    checkOutput("resetDone", {31'd0, t_done_o}, 32'd0);
    checkOutput("resetBusy", {31'd0, busy_o}, 32'd0);
    checkOutput("resetFull", {31'd0, fifo_full_o}, 32'd0);
    checkOutput("resetEmpty", {31'd0, fifo_empty_o}, 32'd1);
    checkOutput("resetOverflow", {31'd0, overflow_o}, 32'd0);
    #2 rst_i = 1'b0;

    // Single frames from the table, including the start latency.
    foreach (vecs[i]) begin
      @(negedge clk_i);
      expQ.push_back('{vecs[i].data, vecs[i].effDiv});
      applyStimulus(vecs[i].data, vecs[i].div);
      checkOutput("emptyAfterWrite", {31'd0, fifo_empty_o}, 32'd0);
      checkOutput("txHighBeforePop", {31'd0, tx_o}, 32'd1);
      checkOutput("busyAfterWrite", {31'd0, busy_o}, 32'd1);
      @(negedge clk_i);
      checkOutput("txStartLatency", {31'd0, tx_o}, 32'd0);
      checkOutput("emptyAfterPop", {31'd0, fifo_empty_o}, 32'd1);
      waitIdle(200);
      checkOutput("busyAfterFrame", {31'd0, busy_o}, 32'd0);
    end

    // Back-to-back frames.
    doneTimes.delete();
    baud_div_i = 16'd2;
    foreach (vecs[i]) if (i < 3) begin
      logic [7:0] b;
      b = (i == 0) ? 8'h00 : (i == 1) ? 8'hFF : 8'h3C;
      expQ.push_back('{b, 2});
      tx_data_i = b;
      tx_en_i   = 1'b1;
      @(negedge clk_i);
    end
    tx_en_i = 1'b0;
    waitIdle(200);
    checkOutput("b2bDoneCount", doneTimes.size(), 3);
    if (doneTimes.size() == 3) begin
      checkOutput("b2bGap1", doneTimes[1] - doneTimes[0], 20);
      checkOutput("b2bGap2", doneTimes[2] - doneTimes[1], 20);
    end

    // Overflow: six consecutive writes, the last one dropped.
    baud_div_i = 16'd8;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) expQ.push_back('{8'h10 + 8'(i), 8});
      tx_data_i = 8'h10 + 8'(i);
      tx_en_i   = 1'b1;
      @(negedge clk_i);
    end
    tx_en_i = 1'b0;
    checkOutput("overflowSet", {31'd0, overflow_o}, 32'd1);
    checkOutput("fullAfterBurst", {31'd0, fifo_full_o}, 32'd1);
    waitIdle(1000);
    checkOutput("overflowSticky", {31'd0, overflow_o}, 32'd1);
    checkOutput("fiveFramesSent", expQ.size(), 0);
    ovf_clr_i = 1'b1;
    @(negedge clk_i);
    ovf_clr_i = 1'b0;
    checkOutput("overflowCleared", {31'd0, overflow_o}, 32'd0);

    // Divisor change mid-frame: the queued byte picks up the new value.
    expQ.push_back('{8'hC3, 4});
    expQ.push_back('{8'h69, 6});
    baud_div_i = 16'd4;
    tx_data_i = 8'hC3;
    tx_en_i   = 1'b1;
    @(negedge clk_i);
    tx_data_i = 8'h69;
    @(negedge clk_i);
    tx_en_i = 1'b0;
    repeat (5) @(negedge clk_i);
    baud_div_i = 16'd6;
    waitIdle(300);

    // Write into a full FIFO on the exact edge where a stop bit ends.
    baud_div_i = 16'd2;
    for (int i = 0; i < 5; i++) begin
      expQ.push_back('{8'hE0 + 8'(i), 2});
      tx_data_i = 8'hE0 + 8'(i);
      tx_en_i   = 1'b1;
      @(negedge clk_i);
    end
    tx_en_i = 1'b0;
    repeat (16) @(negedge clk_i);
    checkOutput("fullBeforeStopEnd", {31'd0, fifo_full_o}, 32'd1);
    expQ.push_back('{8'hE5, 2});
    tx_data_i = 8'hE5;
    tx_en_i   = 1'b1;
    @(negedge clk_i);
    tx_en_i = 1'b0;
    checkOutput("doneAtStopEnd", {31'd0, t_done_o}, 32'd1);
    checkOutput("fullAfterPushPop", {31'd0, fifo_full_o}, 32'd1);
    checkOutput("noOverflowOnPushPop", {31'd0, overflow_o}, 32'd0);
    waitIdle(500);

    // Reset in the middle of the data bits.
    expQ.push_back('{8'hAA, 4});
    expQ.push_back('{8'h55, 4});
    baud_div_i = 16'd4;
    tx_data_i = 8'hAA;
    tx_en_i   = 1'b1;
    @(negedge clk_i);
    tx_data_i = 8'h55;
    @(negedge clk_i);
    tx_en_i = 1'b0;
    repeat (10) @(negedge clk_i);
    snap = doneCount;
    #2 rst_i = 1'b1;
    #1;
    checkOutput("rstTxHigh", {31'd0, tx_o}, 32'd1);
    checkOutput("rstEmpty", {31'd0, fifo_empty_o}, 32'd1);
    checkOutput("rstBusy", {31'd0, busy_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    #2 rst_i = 1'b0;
    expQ.delete();
    repeat (50) @(negedge clk_i);
    checkOutput("noDoneAcrossReset", doneCount, snap);
    expQ.push_back('{8'h96, 4});
    applyStimulus(8'h96, 16'd4);
    waitIdle(200);

    checkOutput("queueDrained", expQ.size(), 0);
    checkOutput("strayDonePulses", strayDone, 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Serial transmitter for the UART peripheral. It sits directly downstream of the AXI-Lite UART register interface. It accepts byte-write pulses and the bit-period divisor from that interface, buffers the bytes in a small FIFO, and shifts them out as 8N1 frames on the serial line. It returns a per-byte completion pulse that feeds the interface's `t_done_i`.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4. Transmit FIFO entries; power of two, ≥2.
- `DIV_W`, default 16. Width of the bit-period divisor.

Ports:
- `clk_i`  in  1  system clock (same clock as the AXI-Lite UART interface)
- `rst_i`  in  1  reset, asynchronous, active-high
- `tx_en_i`  in  1  one-cycle write strobe (driven by the interface's `tx_en_o`)
- `tx_data_i`  in  8  byte to send, sampled when `tx_en_i`=1 (driven by `tx_o`)
- `baud_div_i`  in  DIV_W  clock cycles per bit (driven by `baud_div_o`)
- `ovf_clr_i`  in  1  clears `overflow_o`
- `tx_o`  out  1  serial line, idle high
- `t_done_o`  out  1  one-cycle pulse per completed frame (to `t_done_i`)
- `busy_o`  out  1  frame in progress or FIFO non-empty
- `fifo_full_o`  out  1  FIFO holds FIFO_DEPTH bytes
- `fifo_empty_o`  out  1  FIFO holds 0 bytes
- `overflow_o`  out  1  sticky: a write arrived while the FIFO was full

## Operation
- **FIFO.** Circular buffer with read and write pointers and a count register of width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- **Write with FIFO not full.** `tx_en_i`=1 stores the byte and increments the count.
- **Write with FIFO full and no pop this cycle.** The byte is dropped and `overflow_o` is set. `overflow_o` stays set until `ovf_clr_i` or reset. If `ovf_clr_i` and a new overflow occur in the same cycle, set wins.
- **Write and pop in the same cycle.** Always accepted, even when full. The count is unchanged.
- **State machine.** States are IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is not empty, pop the head byte into the shift register, latch `baud_div_i` into `div_q`, clear the bit counter, and go to START.
  - START: `tx_o`=0 for `div_q` cycles, then go to DATA.
  - DATA: shift out 8 bits, LSB first, each for `div_q` cycles. A 3-bit index counts the bits; after bit 7, go to STOP.
  - STOP: `tx_o`=1 for `div_q` cycles. At the end, pulse `t_done_o`. If the FIFO is not empty, pop and go to START in that same cycle, so frames run back-to-back with no idle gap. Otherwise go to IDLE.
- **Divisor.** `baud_div_i` is latched only at frame start; changes mid-frame do not affect the current frame. A value of 0 is treated as 1.
- **Bit timer.** A down-counter loaded with `div_q`−1. A bit ends when the counter reaches 0.
- **Serial output.** `tx_o` is driven from a register and is glitch-free.

## Timing
- **Reset values.** `tx_o`=1, `t_done_o`=0, `busy_o`=0, `fifo_full_o`=0, `fifo_empty_o`=1, `overflow_o`=0. State is IDLE; pointers and count are 0.
- **Reset mid-frame.** `tx_o` returns to 1 immediately (asynchronously). The FIFO contents are discarded and no `t_done_o` is issued.
- **Start latency.** `tx_en_i` is sampled at edge N with the FIFO empty and the state IDLE. The byte is visible in the FIFO after N. The FSM pops at N+1, and `tx_o` falls after edge N+1.
- **Frame length.** Exactly 10·`div_q` cycles from the falling edge of the start bit to the end of the stop bit.
- **Completion pulse.** `t_done_o` is high for exactly the one cycle following the last stop-bit cycle.
- **Status flags.** `fifo_full_o` and `fifo_empty_o` are registered and reflect the count after each edge. `busy_o` = (state≠IDLE) | ~`fifo_empty_o`.
- **Throughput.** The maximum sustained rate is one byte per 10·`div_q` cycles. Writes faster than that fill the FIFO.

## Test plan
- **Single byte.** Reset, `baud_div_i`=4, write 0xA5. Required: `tx_o` sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total). `t_done_o` pulses once, then `busy_o`=0.
- **Back-to-back.** `baud_div_i`=2, write 0x00, 0xFF, 0x3C on consecutive cycles. Required: three frames, 60 cycles with no idle high gap between frames, three `t_done_o` pulses 20 cycles apart.
- **Overflow.** `baud_div_i`=8, write 6 bytes in 6 consecutive cycles. Required: the first byte is in flight, the next 4 fill the FIFO, the 6th is dropped, `overflow_o`=1, and only 5 frames are sent. Then `ovf_clr_i` clears `overflow_o`.
- **Divisor change and zero divisor.** Change `baud_div_i` 4→6 mid-frame. Required: the current frame keeps 4-cycle bits; the next frame uses 6. Also, `baud_div_i`=0 gives 1-cycle bits (10-cycle frame).
- **Reset mid-frame.** Assert `rst_i` during DATA. Required: `tx_o`=1 immediately, `fifo_empty_o`=1, no `t_done_o`, and a clean frame after release.
- **Simultaneous write and pop when full.** FIFO full, write at the cycle STOP ends. Required: byte accepted, `overflow_o` stays 0, `fifo_full_o` stays 1.
